data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the processor's data-memory interface: a word-addressed synchronous SRAM of DEPTH 32-bit words that services the core's CEN/WEN/OEN/A/Data2Mem requests and returns ReadDataMem. On reset release it runs a clear sequence that zeroes every word. It also provides a side-band preload port (valid/ready handshake) for the testbench or a boot loader, and saturating read/write access counters for debug.

## Interface
Parameters:
- DEPTH, 128, number of 32-bit words
- AW, 7, address width, log2(DEPTH)
- DW, 32, data width
- CNT_W, 16, width of each access counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- CEN  in  1  chip enable, active-low; 0 = access this cycle
- WEN  in  1  write enable, active-low; 0 = write, 1 = read (qualified by CEN=0)
- OEN  in  1  output enable, active-low; gates ReadDataMem
- A  in  AW  word address
- Data2Mem  in  DW  write data
- ReadDataMem  out  DW  read data
- ld_valid  in  1  preload request
- ld_ready  out  1  preload accepted when ld_valid & ld_ready at a clock edge
- ld_addr  in  AW  preload word address
- ld_data  in  DW  preload data
- busy  out  1  clear sequence in progress
- err_access  out  1  one-cycle pulse: core access attempted while busy
- rd_cnt  out  CNT_W  core reads performed, saturating
- wr_cnt  out  CNT_W  core writes performed, saturating

## Operation
- FSM states: CLEAR, RUN.
- rst_n low: state=CLEAR, clear index=0, q_reg=0, counters=0, err_access=0. The array itself is not reset.
- CLEAR: each edge writes 0 to mem[index] and increments index. The edge that writes index DEPTH-1 moves the FSM to RUN. busy=1 in CLEAR. Core accesses are ignored: no array change, q_reg holds, counters hold. err_access is set for one cycle on the edge that samples CEN=0. ld_ready=0.
- RUN: busy=0.
- Core read (CEN=0, WEN=1): q_reg <= mem[A]; rd_cnt increments.
- Core write (CEN=0, WEN=0): mem[A] <= Data2Mem; q_reg holds (no write-through); wr_cnt increments.
- Core idle (CEN=1): q_reg holds.
- ReadDataMem = OEN ? 0 : q_reg. This is combinational gating only; OEN has no effect on state.
- Preload: ld_ready = (state==RUN) & CEN (core idle). On handshake, mem[ld_addr] <= ld_data. The core always has priority, so two writes to the array in one cycle are impossible. A preload neither alters q_reg nor changes counters.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- A ≥ DEPTH cannot occur at the default parameters. For non-power-of-two DEPTH, out-of-range addresses are ignored: reads return 0 into q_reg, writes are dropped. Counters still increment.

## Timing
- Read latency: 1 edge. The address sampled at edge N appears on ReadDataMem after edge N, provided OEN=0.
- Write: takes effect at the sampling edge. A read of the same address at the next edge returns the new data. A read and write in the same cycle cannot occur, because WEN selects one.
- busy is high from rst_n assertion through exactly DEPTH rising edges after release (128 at default). It is low after the edge that clears word DEPTH-1.
- err_access is registered: high for the cycle following each offending edge, and low otherwise.
- ld_ready is combinational from CEN and state. A CEN change within a cycle changes ld_ready in the same cycle.
- Reset asserted mid-CLEAR or mid-RUN: all outputs return to reset values asynchronously (ReadDataMem=0, busy=1, ld_ready=0, counters=0). The clear restarts at index 0 after release.
- Reset values: ReadDataMem=0, busy=1, ld_ready=0, err_access=0, rd_cnt=0, wr_cnt=0.

## Test plan
- Reset then release; hold CEN=1 for 130 edges -> busy falls exactly after edge 128. Afterwards, reads of addresses 0, 63 and 127 return 0x00000000.
- RUN: write 0xDEADBEEF to A=5, then read A=5 with OEN=0 -> ReadDataMem=0xDEADBEEF one edge after the read. With OEN=1 -> ReadDataMem=0. wr_cnt=1, rd_cnt=1.
- During CLEAR, pulse CEN=0 with WEN=0, A=3, Data2Mem=0x12345678 -> err_access high for one cycle. After CLEAR, read A=3 returns 0; counters remain 0.
- RUN: hold ld_valid=1, ld_addr=9, ld_data=0xA5A5A5A5 while CEN=0 for 3 cycles -> ld_ready=0 and no preload. When CEN rises, the handshake completes in one edge, and a subsequent core read of A=9 returns 0xA5A5A5A5.
- Force wr_cnt to near saturation, using CNT_W=4 with 17 core writes -> wr_cnt stops at 15.
- Assert rst_n low at clear index 60, then release -> busy stays high for a further full 128 edges. A word written by preload before the reset reads 0 afterwards.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Core-side data-memory bus plus the side-band preload handshake.
// The master drives requests; the slave (the memory responder) returns
// read data and the preload ready.
interface data_mem_responder_if #(
   parameter int AW = 7,
   parameter int DW = 32
);
   logic          CEN;
   logic          WEN;
   logic          OEN;
   logic [AW-1:0] A;
   logic [DW-1:0] Data2Mem;
   logic [DW-1:0] ReadDataMem;
   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;

   modport master (
      output CEN, WEN, OEN, A, Data2Mem, ld_valid, ld_addr, ld_data,
      input  ReadDataMem, ld_ready
   );

   modport slave (
      input  CEN, WEN, OEN, A, Data2Mem, ld_valid, ld_addr, ld_data,
      output ReadDataMem, ld_ready
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed synchronous data memory answering the core's CEN/WEN/OEN
// requests. After reset release it zeroes every word (CLEAR), then serves
// core reads/writes and side-band preloads (RUN). Saturating access
// counters are kept for debug.
module data_mem_responder #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_responder_if.slave  bus,
   output logic                 busy,
   output logic                 err_access,
   output logic [CNT_W-1:0]     rd_cnt,
   output logic [CNT_W-1:0]     wr_cnt
);

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam int unsigned   DEPTH_U  = DEPTH;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] clr_idx;
   logic          clr_last;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] q_reg;
   logic          core_rd;
   logic          core_wr;
   logic          ld_fire;
   logic          a_in_range;
   logic          ld_in_range;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Addresses beyond DEPTH only exist for non-power-of-two depths.
   assign a_in_range  = (32'(bus.A) < DEPTH_U);
   assign ld_in_range = (32'(bus.ld_addr) < DEPTH_U);
   assign clr_last    = (clr_idx == LAST_IDX);

   assign core_rd = (state == RUN) & ~bus.CEN &  bus.WEN;
   assign core_wr = (state == RUN) & ~bus.CEN & ~bus.WEN;
   assign ld_fire = bus.ld_valid & bus.ld_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_next;
   end

   // Next state: leave CLEAR on the edge that zeroes the last word.
   always_comb begin
      state_next = state;
      unique case (state)
         CLEAR:   if (clr_last) state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = CLEAR;
      endcase
   end

   // State-decoded outputs; preload is only offered while the core is idle.
   always_comb begin
      busy         = 1'b1;
      bus.ld_ready = 1'b0;
      unique case (state)
         CLEAR: begin
            busy         = 1'b1;
            bus.ld_ready = 1'b0;
         end
         RUN: begin
            busy         = 1'b0;
            bus.ld_ready = bus.CEN;
         end
         default: begin
            busy         = 1'b1;
            bus.ld_ready = 1'b0;
         end
      endcase
   end

   // Clear index walks 0..DEPTH-1 once per clear sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               clr_idx <= '0;
      else if (state == CLEAR)  clr_idx <= clr_last ? '0 : clr_idx + AW'(1);
   end

   // Single array write port: clear, then core write, then preload.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_idx;
      mem_wdata = '0;
      if (state == CLEAR) begin
         mem_we = 1'b1;
      end else if (core_wr) begin
         mem_we    = a_in_range;
         mem_waddr = bus.A;
         mem_wdata = bus.Data2Mem;
      end else if (ld_fire) begin
         mem_we    = ld_in_range;
         mem_waddr = bus.ld_addr;
         mem_wdata = bus.ld_data;
      end
   end

   // Storage array, deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Read register: loads only on a core read, holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       q_reg <= '0;
      else if (core_rd) q_reg <= a_in_range ? mem[bus.A] : '0;
   end

   // Flag core accesses that arrive while the clear is still running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_access <= 1'b0;
      else        err_access <= (state == CLEAR) & ~bus.CEN;
   end

   // Saturating debug counters of completed core accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (core_rd) rd_cnt <= sat_inc(rd_cnt);
         if (core_wr) wr_cnt <= sat_inc(wr_cnt);
      end
   end

   assign bus.ReadDataMem = bus.OEN ? '0 : q_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a reference model tracks the memory image,
// clear progress and counters; read results are queued as they are issued
// and a negedge monitor compares every DUT output against the model.
module tb_data_mem_responder;
   localparam int DEPTH = 128;
   localparam int AW    = 7;
   localparam int DW    = 32;
   localparam int CNT_W = 16;
   localparam int MAX16 = 65535;
   localparam int MAX4  = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_responder_if #(.AW(AW), .DW(DW)) bus ();
   data_mem_responder_if #(.AW(AW), .DW(DW)) bus4 ();

   logic             busy, err_access;
   logic [CNT_W-1:0] rd_cnt, wr_cnt;
   logic             busy4, err4;
   logic [3:0]       rd_cnt4, wr_cnt4;

   data_mem_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy),
      .err_access(err_access), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
   );

   data_mem_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .busy(busy4),
      .err_access(err4), .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4)
   );

   assign bus4.CEN      = bus.CEN;
   assign bus4.WEN      = bus.WEN;
   assign bus4.OEN      = bus.OEN;
   assign bus4.A        = bus.A;
   assign bus4.Data2Mem = bus.Data2Mem;
   assign bus4.ld_valid = bus.ld_valid;
   assign bus4.ld_addr  = bus.ld_addr;
   assign bus4.ld_data  = bus.ld_data;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int m);
      return (v < m) ? v + 1 : m;
   endfunction

   // Reference model.
   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] exp_q [$];
   int clr_edges = 0;
   int rd_m = 0, wr_m = 0, rd4_m = 0, wr4_m = 0;
   bit err_m = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_edges = 0;
         rd_m = 0; wr_m = 0; rd4_m = 0; wr4_m = 0;
         err_m = 1'b0;
         exp_q.delete();
      end else if (clr_edges < DEPTH) begin
         mem_m[clr_edges] = '0;
         clr_edges++;
         err_m = !bus.CEN;
      end else begin
         err_m = 1'b0;
         if (!bus.CEN && bus.WEN) begin
            exp_q.push_back(mem_m[bus.A]);
            rd_m  = sat(rd_m, MAX16);
            rd4_m = sat(rd4_m, MAX4);
         end else if (!bus.CEN) begin
            mem_m[bus.A] = bus.Data2Mem;
            wr_m  = sat(wr_m, MAX16);
            wr4_m = sat(wr4_m, MAX4);
         end else if (bus.ld_valid) begin
            mem_m[bus.ld_addr] = bus.ld_data;
         end
      end
   end

   // Monitor.
   logic [DW-1:0] last_q = '0;
   logic          exp_busy;
   logic [DW-1:0] exp_rd;

   always @(negedge clk) begin
      if (!rst_n) last_q = '0;
      else if (exp_q.size() > 0) last_q = exp_q.pop_front();
      exp_busy = (clr_edges < DEPTH);
      exp_rd   = bus.OEN ? '0 : last_q;
      chk("ReadDataMem", bus.ReadDataMem, exp_rd);
      chk("ReadDataMem4", bus4.ReadDataMem, exp_rd);
      chk("busy", busy, exp_busy);
      chk("busy4", busy4, exp_busy);
      chk("ld_ready", bus.ld_ready, !exp_busy && bus.CEN);
      chk("ld_ready4", bus4.ld_ready, !exp_busy && bus.CEN);
      chk("err_access", err_access, err_m);
      chk("err_access4", err4, err_m);
      chk("rd_cnt", rd_cnt, rd_m);
      chk("wr_cnt", wr_cnt, wr_m);
      chk("rd_cnt4", rd_cnt4, rd4_m);
      chk("wr_cnt4", wr_cnt4, wr4_m);
   end

   // Stimulus helpers.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.CEN = 1'b1;
      bus.WEN = 1'b1;
   endtask

   task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.CEN = 1'b0; bus.WEN = 1'b0; bus.A = a; bus.Data2Mem = d;
      tick();
      idle();
   endtask

   task automatic core_read(input logic [AW-1:0] a, input logic oen);
      bus.CEN = 1'b0; bus.WEN = 1'b1; bus.A = a; bus.OEN = oen;
      tick();
      idle();
   endtask

   // Release reset and run the clear; optionally poke the core at edge
   // pulse_at and re-assert reset after abort_at edges.
   task automatic clear_phase(input int pulse_at, input int abort_at, input int expect_edges);
      int n;
      n = 0;
      rst_n = 1'b1;
      while (busy && n < 300) begin
         if (n == pulse_at) begin
            bus.CEN = 1'b0; bus.WEN = 1'b0; bus.A = 3; bus.Data2Mem = 32'h12345678;
         end else begin
            idle();
         end
         tick();
         n++;
         if (n == pulse_at + 1) chk("err_pulse", err_access, 1'b1);
         if (n == pulse_at + 2) chk("err_drop", err_access, 1'b0);
         if (n == abort_at) begin
            idle();
            rst_n = 1'b0;
            #1;
            chk("async_busy", busy, 1'b1);
            chk("async_ld_ready", bus.ld_ready, 1'b0);
            return;
         end
      end
      idle();
      chk("clear_edges", n, expect_edges);
   endtask

   initial begin
      idle();
      bus.OEN = 1'b0; bus.A = '0; bus.Data2Mem = '0;
      bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
      repeat (3) tick();
      chk("reset_busy", busy, 1'b1);
      chk("reset_rdata", bus.ReadDataMem, '0);
      chk("reset_rd_cnt", rd_cnt, '0);

      clear_phase(-1, -1, DEPTH);
      repeat (2) tick();
      core_read(0, 1'b0);
      core_read(63, 1'b0);
      core_read(127, 1'b0);
      chk("cleared_127", bus.ReadDataMem, '0);

      core_write(5, 32'hDEADBEEF);
      core_read(5, 1'b0);
      chk("read5", bus.ReadDataMem, 32'hDEADBEEF);
      bus.OEN = 1'b1;
      #1;
      chk("read5_oen", bus.ReadDataMem, '0);
      bus.OEN = 1'b0;
      tick();

      bus.ld_valid = 1'b1; bus.ld_addr = 9; bus.ld_data = 32'hA5A5A5A5;
      bus.CEN = 1'b0; bus.WEN = 1'b1; bus.A = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ld_blocked", bus.ld_ready, 1'b0);
         tick();
      end
      idle();
      #1;
      chk("ld_open", bus.ld_ready, 1'b1);
      tick();
      bus.ld_valid = 1'b0;
      core_read(9, 1'b0);
      chk("read9", bus.ReadDataMem, 32'hA5A5A5A5);

      for (int i = 0; i < 17; i++) core_write(AW'(i + 20), $urandom);
      chk("wr_sat4", wr_cnt4, 4'd15);

      bus.ld_valid = 1'b1; bus.ld_addr = 100; bus.ld_data = 32'h55AA55AA;
      tick();
      bus.ld_valid = 1'b0;
      core_read(100, 1'b0);
      chk("read100", bus.ReadDataMem, 32'h55AA55AA);

      rst_n = 1'b0;
      repeat (3) tick();
      clear_phase(10, 60, 0);
      repeat (3) tick();
      clear_phase(-1, -1, DEPTH);
      chk("post_clear_rd_cnt", rd_cnt, '0);
      chk("post_clear_wr_cnt", wr_cnt, '0);
      core_read(3, 1'b0);
      core_read(100, 1'b0);
      chk("read100_cleared", bus.ReadDataMem, '0);
      core_read(9, 1'b0);

      for (int i = 0; i < 2000; i++) begin
         bus.CEN      = ($urandom_range(0, 2) == 0);
         bus.WEN      = $urandom_range(0, 1);
         bus.OEN      = ($urandom_range(0, 3) == 0);
         bus.A        = AW'($urandom);
         bus.Data2Mem = $urandom;
         bus.ld_valid = $urandom_range(0, 1);
         bus.ld_addr  = AW'($urandom);
         bus.ld_data  = $urandom;
         tick();
      end
      idle();
      bus.ld_valid = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
